// File: rtl/vga_pkg.sv
// Shared types and timing defaults for the VGA output formatter.
// Stats logic in vga_tx_fmt is built only with VGA_TX_STATS_EN.
package vga_pkg;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ACTIVE,
    H_FP,
    H_SYNC
  } h_state_t;

  localparam int DEF_ACTIVE_H    = 1920;
  localparam int DEF_H_FP        = 88;
  localparam int DEF_HSYNC_W     = 44;
  localparam int DEF_VSYNC_LINES = 5;

  function automatic logic sync_level(
    input logic active,
    input logic active_low
  );
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registered 1-bit edge detector: compares d with its value
// from the previous clock.
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/vga_tx_fmt.sv
// VGA output formatter: RGB blanking, HSync/VSync generation.
// Define VGA_TX_STATS_EN to build line/frame counters and o_err.
module vga_tx_fmt
  import vga_pkg::*;
#(
  parameter int PIXEL_DATA      = 8,
  parameter int ACTIVE_H        = DEF_ACTIVE_H,
  parameter int H_FRONT_PORCH   = DEF_H_FP,
  parameter int HSYNC_WIDTH     = DEF_HSYNC_W,
  parameter int VSYNC_LINES     = DEF_VSYNC_LINES,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int CNT_W           = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PIXEL_DATA-1:0] i_R_data,
  input  logic [PIXEL_DATA-1:0] i_G_data,
  input  logic [PIXEL_DATA-1:0] i_B_data,
  input  logic                  i_VSync,
  input  logic                  i_DE,
  output logic [PIXEL_DATA-1:0] o_R_data,
  output logic [PIXEL_DATA-1:0] o_G_data,
  output logic [PIXEL_DATA-1:0] o_B_data,
  output logic                  o_DE,
  output logic                  o_HSync,
  output logic                  o_VSync,
  output logic [CNT_W-1:0]      o_line_cnt,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_err
);

  localparam logic SAL = (SYNC_ACTIVE_LOW != 0);

  logic [PIXEL_DATA-1:0] s1_r, s1_g, s1_b;
  logic s1_de, s1_vs;
  logic de_rise, de_fall;
  logic vs_rise, vs_fall_unused;

  h_state_t state;
  logic [CNT_W-1:0] porch_cnt;
  logic [CNT_W-1:0] vline;
  logic hs_entered;
  logic vs_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_de    <= 1'b0;
      s1_vs    <= 1'b0;
      o_R_data <= '0;
      o_G_data <= '0;
      o_B_data <= '0;
      o_DE     <= 1'b0;
    end else begin
      s1_r     <= i_R_data;
      s1_g     <= i_G_data;
      s1_b     <= i_B_data;
      s1_de    <= i_DE;
      s1_vs    <= i_VSync;
      o_R_data <= s1_de ? s1_r : '0;
      o_G_data <= s1_de ? s1_g : '0;
      o_B_data <= s1_de ? s1_b : '0;
      o_DE     <= s1_de;
    end
  end

  vga_edge_det u_de_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (s1_de),
    .rise (de_rise),
    .fall (de_fall)
  );

  vga_edge_det u_vs_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (s1_vs),
    .rise (vs_rise),
    .fall (vs_fall_unused)
  );

  // HSync is set/cleared on the same edge the state changes,
  // so it lines up with the stage-2 data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= H_IDLE;
      porch_cnt  <= '0;
      hs_entered <= 1'b0;
      o_HSync    <= sync_level(1'b0, SAL);
    end else begin
      hs_entered <= 1'b0;
      unique case (state)
        H_IDLE: begin
          if (de_rise) state <= H_ACTIVE;
        end
        H_ACTIVE: begin
          if (de_fall) begin
            state     <= H_FP;
            porch_cnt <= '0;
          end
        end
        H_FP: begin
          if (de_rise) begin
            state <= H_ACTIVE;
          end else if (32'(porch_cnt) == H_FRONT_PORCH - 1) begin
            state      <= H_SYNC;
            porch_cnt  <= '0;
            hs_entered <= 1'b1;
            o_HSync    <= sync_level(1'b1, SAL);
          end else begin
            porch_cnt <= porch_cnt + 1'b1;
          end
        end
        H_SYNC: begin
          if (de_rise) begin
            state   <= H_ACTIVE;
            o_HSync <= sync_level(1'b0, SAL);
          end else if (32'(porch_cnt) == HSYNC_WIDTH - 1) begin
            state   <= H_IDLE;
            o_HSync <= sync_level(1'b0, SAL);
          end else begin
            porch_cnt <= porch_cnt + 1'b1;
          end
        end
        default: state <= H_IDLE;
      endcase
    end
  end

  // A frame start always wins over the line count of the old pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_active <= 1'b0;
      vline     <= '0;
      o_VSync   <= sync_level(1'b0, SAL);
    end else if (vs_rise) begin
      vs_active <= 1'b1;
      vline     <= '0;
      o_VSync   <= sync_level(1'b1, SAL);
    end else if (hs_entered && vs_active) begin
      if (32'(vline) + 1 >= VSYNC_LINES) begin
        vs_active <= 1'b0;
        vline     <= '0;
        o_VSync   <= sync_level(1'b0, SAL);
      end else begin
        vline <= vline + 1'b1;
      end
    end
  end

`ifdef VGA_TX_STATS_EN
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [15:0] frame_cnt;
  logic err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (de_rise)
        pix_cnt <= CNT_W'(1);
      else if (s1_de && pix_cnt != '1)
        pix_cnt <= pix_cnt + 1'b1;
      if (de_fall && state == H_ACTIVE &&
          32'(pix_cnt) != ACTIVE_H)
        err <= 1'b1;
      if (de_rise && (state == H_FP || state == H_SYNC))
        err <= 1'b1;
      if (vs_rise && vs_active)
        err <= 1'b1;
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 1'b1;
        line_cnt  <= de_rise ? CNT_W'(1) : '0;
      end else if (de_rise && line_cnt != '1) begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  assign o_line_cnt  = line_cnt;
  assign o_frame_cnt = frame_cnt;
  assign o_err       = err;
`else
  assign o_line_cnt  = '0;
  assign o_frame_cnt = '0;
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_vga_tx_fmt.sv
// Randomized bench for vga_tx_fmt with an output-domain reference model.
// Build with or without VGA_TX_STATS_EN to match the RTL.
module tb_vga_tx_fmt;

  localparam int AH  = 8;
  localparam int FP  = 2;
  localparam int HSW = 3;
  localparam int VSW = 2;
  localparam logic SAL = 1'b1;
`ifdef VGA_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic [7:0] i_R_data = '0, i_G_data = '0, i_B_data = '0;
  logic i_VSync = 1'b0, i_DE = 1'b0;
  logic [7:0] o_R_data, o_G_data, o_B_data;
  logic o_DE, o_HSync, o_VSync, o_err;
  logic [11:0] o_line_cnt;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_tx_fmt #(
    .ACTIVE_H      (AH),
    .H_FRONT_PORCH (FP),
    .HSYNC_WIDTH   (HSW),
    .VSYNC_LINES   (VSW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_R_data    (i_R_data),
    .i_G_data    (i_G_data),
    .i_B_data    (i_B_data),
    .i_VSync     (i_VSync),
    .i_DE        (i_DE),
    .o_R_data    (o_R_data),
    .o_G_data    (o_G_data),
    .o_B_data    (o_B_data),
    .o_DE        (o_DE),
    .o_HSync     (o_HSync),
    .o_VSync     (o_VSync),
    .o_line_cnt  (o_line_cnt),
    .o_frame_cnt (o_frame_cnt),
    .o_err       (o_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h",
               nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic rst; logic de; logic vs;
    logic [7:0] r; logic [7:0] g; logic [7:0] b;
  } smp_t;

  smp_t d1 = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
  smp_t d2 = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};

  int cyc = 0;
  int last_fall = 0;
  bit fall_valid = 0;
  int run = 0;
  bit p_ode = 0, p_ovs = 0, p_hs = 0, p_entry = 0;
  bit m_on = 0;
  int m_vcnt = 0;
  int m_line = 0;
  int m_frame = 0;
  bit m_err = 0;
  int n_de = 0, n_hs = 0, n_vs = 0;

  // Output cycle n reflects inputs driven in cycle n-2.
  always @(negedge clk) begin
    smp_t cur;
    bit ode, ovs, dr, df, vr, hs;
    logic [7:0] er, eg, eb;
    int dt;
    cyc++;
    cur = '{i_rst, i_DE, i_VSync, i_R_data, i_G_data, i_B_data};
    if (d1.rst) begin
      ode = 0; ovs = 0; hs = 0; er = 0; eg = 0; eb = 0;
      fall_valid = 0; run = 0; m_on = 0; m_vcnt = 0;
      m_line = 0; m_frame = 0; m_err = 0;
      p_entry = 0;
    end else begin
      ode = !d2.rst && d2.de;
      ovs = !d2.rst && d2.vs;
      er = ode ? d2.r : 8'd0;
      eg = ode ? d2.g : 8'd0;
      eb = ode ? d2.b : 8'd0;
      dr = ode && !p_ode;
      df = !ode && p_ode;
      vr = ovs && !p_ovs;
      if (df) begin
        if (run != AH) m_err = 1;
        fall_valid = 1;
        last_fall = cyc;
      end
      if (dr) begin
        if (fall_valid && cyc - last_fall <= FP + HSW) m_err = 1;
        run = 0;
      end
      if (ode) run++;
      dt = cyc - last_fall;
      hs = !ode && fall_valid && dt >= FP && dt <= FP + HSW - 1;
      if (vr) begin
        if (m_on) m_err = 1;
        m_on = 1;
        m_vcnt = 0;
      end else if (p_entry && m_on) begin
        m_vcnt++;
        if (m_vcnt >= VSW) m_on = 0;
      end
      if (vr) begin
        m_frame = (m_frame + 1) % 65536;
        m_line = dr ? 1 : 0;
      end else if (dr && m_line != 4095) begin
        m_line++;
      end
      p_entry = hs && !p_hs;
    end
    p_ode = ode;
    p_ovs = ovs;
    p_hs = hs;
    chk("de", 32'(o_DE), 32'(ode));
    chk("r", 32'(o_R_data), 32'(er));
    chk("g", 32'(o_G_data), 32'(eg));
    chk("b", 32'(o_B_data), 32'(eb));
    chk("hsync", 32'(o_HSync), 32'(hs ^ SAL));
    chk("vsync", 32'(o_VSync), 32'(m_on ^ SAL));
    chk("line_cnt", 32'(o_line_cnt), STATS ? 32'(m_line) : 32'd0);
    chk("frame_cnt", 32'(o_frame_cnt), STATS ? 32'(m_frame) : 32'd0);
    chk("err", 32'(o_err), STATS ? 32'(m_err) : 32'd0);
    if (o_DE === 1'b1) n_de++;
    if (o_HSync === 1'b0) n_hs++;
    if (o_VSync === 1'b0) n_vs++;
    d2 = d1;
    d1 = cur;
  end

  task automatic step(input logic rst, input logic de, input logic vs,
                      input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    i_rst = rst; i_DE = de; i_VSync = vs;
    i_R_data = r; i_G_data = g; i_B_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int len, input int gap, input logic [7:0] v);
    for (int k = 0; k < len; k++) step(0, 1, 0, v, v, v);
    for (int k = 0; k < gap; k++) step(0, 0, 0, 8'd255, 8'd255, 8'd255);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a_de, a_hs, a_vs;
    int len, gap, vs_at, rst_at;
    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("rst_hsync_lit", 32'(o_HSync), 32'd1);
    chk("rst_vsync_lit", 32'(o_VSync), 32'd1);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    a_de = n_de; a_hs = n_hs; a_vs = n_vs;
    step(0, 0, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (4) line(AH, 10, 8'd26);
    repeat (20) step(0, 0, 0, 8'd255, 8'd255, 8'd255);
    chk("de_cycles_lit", 32'(n_de - a_de), 32'd32);
    chk("hs_cycles_lit", 32'(n_hs - a_hs), 32'd12);
    chk("vs_cycles_lit", 32'(n_vs - a_vs), 32'd32);
    chk("line_cnt_lit", 32'(o_line_cnt), STATS ? 32'd4 : 32'd0);
    chk("frame_cnt_lit", 32'(o_frame_cnt), STATS ? 32'd1 : 32'd0);
    chk("err_clean_lit", 32'(o_err), 32'd0);

    line(7, 10, 8'd40);
    chk("err_short_lit", 32'(o_err), STATS ? 32'd1 : 32'd0);
    line(AH, 10, 8'd41);
    chk("err_sticky_lit", 32'(o_err), STATS ? 32'd1 : 32'd0);

    step(1, 0, 0, 0, 0, 0);
    chk("err_rst_lit", 32'(o_err), 32'd0);
    a_hs = n_hs;
    line(AH, 3, 8'd50);
    line(AH, 10, 8'd51);
    chk("hs_cut_lit", 32'(n_hs - a_hs), 32'd4);
    chk("err_cut_lit", 32'(o_err), STATS ? 32'd1 : 32'd0);

    step(1, 0, 0, 0, 0, 0);
    line(AH, 0, 8'd60);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    chk("mid_hs_lit", 32'(o_HSync), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mid_hs_lit", 32'(o_HSync), 32'd1);
    chk("rst_mid_de_lit", 32'(o_DE), 32'd0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      len = ($urandom_range(9) == 0) ? (($urandom_range(1) == 0) ? 7 : 9) : AH;
      gap = ($urandom_range(7) == 0) ? int'($urandom_range(1, 5))
                                     : int'($urandom_range(6, 14));
      vs_at = ($urandom_range(5) == 0) ? int'($urandom_range(0, len + gap - 1)) : -1;
      rst_at = ($urandom_range(29) == 0) ? int'($urandom_range(0, len + gap - 1)) : -1;
      for (int k = 0; k < len + gap; k++)
        step(k == rst_at, k < len, k == vs_at,
             8'($urandom), 8'($urandom), 8'($urandom));
    end
    repeat (20) step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
